// File: rtl/alu_seq_arbiter.sv
// alu_seq_arbiter: round-robin arbiter for two requesters that share one 8-bit ALU.
// Each 16-bit operation (ADD/SUB/OR/AND) is split into two passes. The LO pass handles
// the low bytes, and the HI pass then handles the high bytes using the carry-chained
// ALU function (ADC/SBC). The 16-bit result is returned through a valid/ready
// response channel.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b          requester N operation handshake (N = 0, 1)
//   rsp_valid/ready/id/result/flags  response handshake, flags = {V,N,C,Z}
//   rsp_err                          illegal-op indication (only with ALU_SEQ_ERR_EN)
//   alu_fsel/opa/opb                 drive the shared 8-bit ALU
//   alu_result/sreg                  ALU outputs, sreg = {V,N,C,Z}
//
// Configuration macro: ALU_SEQ_ERR_EN.
//   Defined:   illegal ops (op[2] set) skip the ALU passes and respond with rsp_err = 1.
//   Undefined: illegal ops execute as ADD16.
module alu_seq_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
`ifdef ALU_SEQ_ERR_EN
  output logic        rsp_err,
`endif
  output logic [3:0]  alu_fsel,
  output logic [7:0]  alu_opa,
  output logic [7:0]  alu_opb,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_sreg
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;      // id served last; reset to 1 so req0 wins first
  logic        id_q, id_d;
  logic [1:0]  op_q, op_d;          // effective op, illegal already folded to ADD
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic [7:0]  lo_res_q, lo_res_d;
  logic        lo_z_q, lo_z_d;
  logic [3:0]  fsel_q, fsel_d;
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
`ifdef ALU_SEQ_ERR_EN
  logic        err_q, err_d;
`endif

  logic        idle, grant0, grant1, accept;
  logic [2:0]  sel_op;
  logic [1:0]  eff_op;
  logic [15:0] sel_a, sel_b;

  function automatic logic [3:0] lo_fsel(input logic [1:0] op);
    unique case (op)
      2'b00:   lo_fsel = 4'b0001;
      2'b01:   lo_fsel = 4'b0010;
      2'b10:   lo_fsel = 4'b0110;
      default: lo_fsel = 4'b0111;
    endcase
  endfunction

  // Carry-chained variants so the HI pass consumes the LO carry/borrow.
  function automatic logic [3:0] hi_fsel(input logic [1:0] op);
    unique case (op)
      2'b00:   hi_fsel = 4'b0011;
      2'b01:   hi_fsel = 4'b0100;
      2'b10:   hi_fsel = 4'b0110;
      default: hi_fsel = 4'b0111;
    endcase
  endfunction

  always_comb begin
    idle   = (state_q == StIdle);
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
    accept = idle & (grant0 | grant1);
    sel_op = grant1 ? req1_op : req0_op;
    sel_a  = grant1 ? req1_a : req0_a;
    sel_b  = grant1 ? req1_b : req0_b;
    eff_op = sel_op[2] ? 2'b00 : sel_op[1:0];
  end

  // Gated by rst_n so no grant is visible while reset is held.
  assign req0_ready = rst_n & idle & grant0;
  assign req1_ready = rst_n & idle & grant1;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    op_d         = op_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    lo_res_d     = lo_res_q;
    lo_z_d       = lo_z_q;
    fsel_d       = fsel_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
`ifdef ALU_SEQ_ERR_EN
    err_d        = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          last_d  = grant1;
          id_d    = grant1;
          op_d    = eff_op;
          a_hi_d  = sel_a[15:8];
          b_hi_d  = sel_b[15:8];
          state_d = StLo;
          fsel_d  = lo_fsel(eff_op);
          opa_d   = sel_a[7:0];
          opb_d   = sel_b[7:0];
`ifdef ALU_SEQ_ERR_EN
          err_d = sel_op[2];
          if (sel_op[2]) begin
            state_d      = StResp;
            fsel_d       = 4'b0000;
            opa_d        = 8'h00;
            opb_d        = 8'h00;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant1;
            rsp_result_d = 16'h0000;
            rsp_flags_d  = 4'b0000;
          end
`endif
        end
      end
      StLo: begin
        lo_res_d = alu_result;
        lo_z_d   = alu_sreg[0];
        state_d  = StHi;
        fsel_d   = hi_fsel(op_q);
        opa_d    = a_hi_q;
        opb_d    = b_hi_q;
      end
      StHi: begin
        rsp_result_d = {alu_result, lo_res_q};
        rsp_flags_d  = {alu_sreg[3:1], alu_sreg[0] & lo_z_q};
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        fsel_d       = 4'b0000;
        opa_d        = 8'h00;
        opb_d        = 8'h00;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= 2'b00;
      a_hi_q       <= 8'h00;
      b_hi_q       <= 8'h00;
      lo_res_q     <= 8'h00;
      lo_z_q       <= 1'b0;
      fsel_q       <= 4'b0000;
      opa_q        <= 8'h00;
      opb_q        <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 16'h0000;
      rsp_flags_q  <= 4'b0000;
`ifdef ALU_SEQ_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      lo_res_q     <= lo_res_d;
      lo_z_q       <= lo_z_d;
      fsel_q       <= fsel_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
`ifdef ALU_SEQ_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign alu_fsel   = fsel_q;
  assign alu_opa    = opa_q;
  assign alu_opb    = opb_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
`ifdef ALU_SEQ_ERR_EN
  assign rsp_err    = err_q;
`endif

endmodule

// File: doc/alu_seq_arbiter.md
ALU_SEQ_ARBITER -- requirements
Module: alu_seq_arbiter

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid, req1_valid  in  1 each  requester n presents an operation.
REQ-005 req0_ready, req1_ready  out  1 each  grant; transfer on valid&ready.
REQ-006 req0_op, req1_op  in  3 each  000 ADD16, 001 SUB16, 010 OR16, 011 AND16, 1xx illegal.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  16 each  operands.
REQ-008 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-009 rsp_id  out  1  requester index; rsp_result  out  16; rsp_flags  out  4  {V,N,C,Z}, bits 3..0.
REQ-010 alu_fsel  out  4; alu_opa, alu_opb  out  8 each  drive shared 8-bit ALU.
REQ-011 alu_result  in  8; alu_sreg  in  4  ALU outputs, SREG[0]=Z, [1]=C, [2]=N, [3]=V.

Function
REQ-012 States IDLE, LO, HI, RESP; IDLE->LO on accepted request, LO->HI unconditionally, HI->RESP unconditionally, RESP->IDLE on rsp_valid&rsp_ready.
REQ-013 In IDLE, at most one of req0_ready/req1_ready is high; ready is high only for the granted requester and only in IDLE; both ready are low in LO, HI and RESP.
REQ-014 Arbitration: round-robin; with both valid, grant the requester not served last; with one valid, grant it; pointer updates only on an accepted transfer.
REQ-015 On acceptance, op, a, b and id are captured into internal registers; requester inputs are ignored until IDLE is re-entered.
REQ-016 LO drives low bytes and fsel ADD 0001, SUB 0010, OR 0110, AND 0111; HI drives high bytes and fsel ADD 0011 (ADC), SUB 0100 (SBC), OR 0110, AND 0111.
REQ-017 alu_result/alu_sreg are sampled at the end of LO (low byte, low Z) and at the end of HI (high byte, flags).
REQ-018 LO and HI are back-to-back cycles; alu_fsel never returns to 0000 between them, preserving ALU carry.
REQ-019 alu_fsel = 0000 and alu_opa = alu_opb = 0 in IDLE and RESP.
REQ-020 rsp_flags: Z = low Z & high Z; C, N, V from the HI pass.
REQ-021 Latency: accept in cycle t; rsp_valid high from cycle t+3; result, flags and id stable while rsp_valid && !rsp_ready.
REQ-022 Arithmetic is modulo 2^16; carry/borrow out of bit 15 is reported only in C.
REQ-023 Back-pressure: a held response blocks all grants; no request is lost or reordered per requester.

Reset
REQ-024 rst_n low, at any time including mid-LO/HI/RESP: state IDLE; rsp_valid, both ready, alu_fsel, alu_opa, alu_opb, rsp_result, rsp_flags, rsp_id are 0; round-robin pointer favours req0; in-flight operation discarded.
REQ-025 First grant is possible in the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro ALU_SEQ_ERR_EN defined: extra port rsp_err (out, 1, reset 0); illegal op skips LO/HI, enters RESP the next cycle with result 0, flags 0, rsp_err 1; legal ops give rsp_err 0.
REQ-027 ALU_SEQ_ERR_EN undefined: no rsp_err port; illegal ops execute as ADD16 with normal timing.

Verification
REQ-028 req0 ADD16 a=0x00FF b=0x0001 -> fsel 0001 then 0011, rsp_result 0x0100, flags 0000, rsp_id 0, rsp_valid at t+3.
REQ-029 req1 SUB16 a=0x0000 b=0x0001 -> fsel 0010 then 0100, rsp_result 0xFFFF, C=1, N=1, Z=0, V=0, rsp_id 1.
REQ-030 req0 OR16 a=0x0000 b=0x0000 with rsp_ready low 5 cycles -> result 0x0000, Z=1, response held unchanged, no ready asserted until handshake.
REQ-031 Both valid every cycle after reset -> grants alternate 0,1,0,1; ready never high on both.
REQ-032 rst_n low during HI of ADD16 -> next edge all outputs 0, state IDLE; later req1-only request is granted and completes normally.
REQ-033 With ALU_SEQ_ERR_EN, op 3'b101 -> rsp_valid at t+1, result 0x0000, rsp_err 1, alu_fsel stays 0000.
